// File: rtl/chan_scan_ctrl.sv
// chan_scan_ctrl: sequences a 4:1 downstream mux select through the enabled
// channels, holding each one for dwell+1 cycles, in single-frame or
// continuous mode.
// Optional feature macro: SCAN_MASK_EN adds the ch_mask input. Without it,
// all four channels are treated as enabled.
module chan_scan_ctrl #(
   parameter int unsigned DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
   input  logic [3:0]         ch_mask,
`endif
   output logic [1:0]         sel,
   output logic               sel_valid,
   output logic               frame_done,
   output logic               busy
);

   localparam int unsigned N_CH = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t             state, nxt_state;
   logic [DWELL_W-1:0] cnt, nxt_cnt;
   logic [DWELL_W-1:0] dwell_q, nxt_dwell;
   logic [N_CH-1:0]    mask_q, nxt_mask;
   logic               cont_q, nxt_cont;
   logic               stop_q, nxt_stop;
   logic [1:0]         nxt_sel;
   logic               nxt_busy;
   logic               nxt_fd;
   logic               stop_eff;
   logic [N_CH-1:0]    mask_in;

`ifdef SCAN_MASK_EN
   assign mask_in = ch_mask;
`else
   assign mask_in = 4'hF;
`endif

   // Lowest enabled channel in a mask.
   function automatic logic [1:0] low_ch(input logic [N_CH-1:0] m);
      low_ch = 2'd0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (m[i]) low_ch = 2'(i);
   endfunction

   // True if any channel above c is enabled.
   function automatic logic has_above(input logic [N_CH-1:0] m, input logic [1:0] c);
      has_above = 1'b0;
      for (int i = 0; i < int'(N_CH); i++)
         if (m[i] && (i > int'(c))) has_above = 1'b1;
   endfunction

   // Next enabled channel above c (c itself if none).
   function automatic logic [1:0] next_above(input logic [N_CH-1:0] m, input logic [1:0] c);
      next_above = c;
      for (int i = N_CH - 1; i >= 0; i--)
         if (m[i] && (i > int'(c))) next_above = 2'(i);
   endfunction

   assign stop_eff = stop_q | stop;

   // Next-state computation; frame_done is predicted one cycle ahead so it
   // can be registered and still coincide with the last dwell cycle.
   always_comb begin
      nxt_state = state;
      nxt_sel   = sel;
      nxt_cnt   = cnt;
      nxt_dwell = dwell_q;
      nxt_mask  = mask_q;
      nxt_cont  = cont_q;
      nxt_stop  = stop_q;
      case (state)
         IDLE: begin
            if (start && !stop && (mask_in != '0)) begin
               nxt_state = SCAN;
               nxt_sel   = low_ch(mask_in);
               nxt_cnt   = '0;
               nxt_dwell = dwell;
               nxt_mask  = mask_in;
               nxt_cont  = continuous;
               nxt_stop  = 1'b0;
            end
         end
         SCAN: begin
            if (cnt != dwell_q) begin
               nxt_cnt  = cnt + DWELL_W'(1);
               nxt_stop = stop_eff;
            end else if (stop_eff) begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
               nxt_stop  = 1'b0;
            end else if (has_above(mask_q, sel)) begin
               nxt_sel = next_above(mask_q, sel);
               nxt_cnt = '0;
            end else if (cont_q && (mask_in != '0)) begin
               nxt_sel   = low_ch(mask_in);
               nxt_cnt   = '0;
               nxt_dwell = dwell;
               nxt_mask  = mask_in;
               nxt_cont  = continuous;
            end else begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
               nxt_stop  = 1'b0;
            end
         end
         default: nxt_state = IDLE;
      endcase
      nxt_busy = (nxt_state == SCAN);
      nxt_fd   = nxt_busy && (nxt_cnt == nxt_dwell) && !has_above(nxt_mask, nxt_sel);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sel        <= 2'd0;
         cnt        <= '0;
         dwell_q    <= '0;
         mask_q     <= '0;
         cont_q     <= 1'b0;
         stop_q     <= 1'b0;
         sel_valid  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         sel        <= nxt_sel;
         cnt        <= nxt_cnt;
         dwell_q    <= nxt_dwell;
         mask_q     <= nxt_mask;
         cont_q     <= nxt_cont;
         stop_q     <= nxt_stop;
         sel_valid  <= nxt_busy;
         busy       <= nxt_busy;
         frame_done <= nxt_fd;
      end
   end

endmodule

// File: doc/chan_scan_ctrl.md
CHAN_SCAN_CTRL -- requirements
Module: chan_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 4: width of the dwell-count input.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a scan frame; sampled in IDLE only.
REQ-005 stop  input  1  request to end scanning after the current channel's dwell completes.
REQ-006 continuous  input  1  1 = repeat frames until stopped; 0 = single frame; sampled at start and at each frame boundary.
REQ-007 dwell  input  DWELL_W  each channel is held for dwell+1 cycles; sampled at start and at each frame boundary.
REQ-008 ch_mask  input  4  per-channel enable (bit i = d_i); present only when SCAN_MASK_EN is defined.
REQ-009 sel  output  2  registered select driving the downstream 4:1 data mux (d0..d3 -> y).
REQ-010 sel_valid  output  1  high while sel addresses a channel in dwell; downstream samples y only when high.
REQ-011 frame_done  output  1  one-cycle pulse on the last dwell cycle of the last enabled channel.
REQ-012 busy  output  1  high in every state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-014 IDLE -> SCAN when start=1, stop=0, and at least one channel is enabled; otherwise stay in IDLE.
REQ-015 The first SCAN cycle (start edge + 1) SHALL present sel = lowest enabled channel with sel_valid=1 and busy=1.
REQ-016 The dwell counter SHALL clear on entry to each channel, increment once per cycle, and expire when it equals the latched dwell.
REQ-017 On expiry, sel SHALL advance to the next higher enabled channel, skipping disabled channels, with no gap cycle (sel_valid stays 1).
REQ-018 On expiry of the highest enabled channel, frame_done SHALL be 1 for that cycle.
REQ-019 At a frame boundary, if continuous=1 and stop has not been latched, sel SHALL wrap to the lowest enabled channel; otherwise SCAN -> IDLE.
REQ-020 stop SHALL be latched when seen in SCAN; at the next dwell expiry the FSM SHALL go to IDLE, with or without frame_done per REQ-018.
REQ-021 start SHALL be ignored in SCAN; stop SHALL be ignored in IDLE, except that start and stop together in IDLE keep the FSM in IDLE.
REQ-022 In IDLE: sel_valid=0, busy=0, frame_done=0, and sel holds its last value.
REQ-023 dwell=0 SHALL give one cycle per channel; dwell = all ones SHALL give 2^DWELL_W cycles per channel without counter wrap.
REQ-024 A change on dwell, continuous or ch_mask mid-frame SHALL NOT take effect before the next frame boundary.

Reset
REQ-025 rst_n low SHALL immediately force the following: IDLE; sel=0, sel_valid=0, frame_done=0, busy=0; dwell counter and stop latch cleared.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse.
REQ-027 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-028 Macro SCAN_MASK_EN defined: the ch_mask port SHALL exist. The mask SHALL be latched at start and at each frame boundary. start with ch_mask=0 SHALL be ignored. A single enabled channel SHALL be rescanned each frame.
REQ-029 Macro SCAN_MASK_EN undefined: the ch_mask port SHALL be absent and all four channels SHALL be treated as enabled.

Verification
REQ-030 dwell=0, continuous=0, full mask, start pulse -> sel 0,1,2,3 on four consecutive cycles, sel_valid=1 for exactly 4 cycles, frame_done on the sel=3 cycle, then IDLE.
REQ-031 dwell=2, continuous=1, stop asserted during the second cycle of sel=1 -> sel=1 held 3 cycles total, then IDLE with no frame_done and sel=1 retained.
REQ-032 SCAN_MASK_EN, ch_mask=4'b1010, dwell=1, continuous=1 -> sel pattern 1,1,3,3,1,1,3,3, with frame_done on every second sel=3 cycle.
REQ-033 start and stop together in IDLE, and start pulsed while busy -> no state change or frame restart in either case.
REQ-034 rst_n low mid-dwell on sel=2 -> all outputs 0 within the same cycle; start after release -> scan restarts at sel=0.
REQ-035 DWELL_W=4, dwell=4'hF -> each channel held exactly 16 cycles, 64-cycle frame.
